// File: rtl/bus_timeout_monitor.sv
// Multi-channel bus timeout monitor: one timeout counter and FSM per master, with
// per-channel sticky status, interrupt, exempt address window and first-error capture.
module bus_timeout_monitor #(
   parameter int              NCH     = 4,
   parameter int              AW      = 32,
   parameter int              CW      = 16,
   parameter int              pTO     = 250,
   parameter logic [AW-1:0]   pEXBASE = 32'hFFDCFFE0,
   parameter logic [AW-1:0]   pEXMASK = 32'hFFFFFFF0
) (
   input  logic              rst_i,
   input  logic              clk_i,
   input  logic [NCH-1:0]    cyc_i,
   input  logic [NCH-1:0]    stb_i,
   input  logic [NCH-1:0]    ack_i,
   input  logic [NCH-1:0]    we_i,
   input  logic [NCH*AW-1:0] adr_i,
   input  logic [CW-1:0]     to_limit_i,
   input  logic [NCH-1:0]    clr_i,
   input  logic [NCH-1:0]    irq_en_i,
   input  logic              cap_clr_i,
   output logic [NCH-1:0]    err_o,
   output logic [NCH-1:0]    err_sticky_o,
   output logic              irq_o,
   output logic              cap_valid_o,
   output logic [3:0]        cap_ch_o,
   output logic [AW-1:0]     cap_adr_o,
   output logic              cap_we_o,
   output logic [7:0]        cap_ovf_o
);

   // Handshake: a request is outstanding on channel n while cyc&stb are high and
   // no ack has been sampled; ack (or cyc dropping) completes it. Once err_o is
   // raised the master must drop cyc to release the channel; ack is ignored then.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   // Per-channel FSM state, kept as an array so it can be probed hierarchically
   state_t          state_q [NCH];
   state_t          state_d [NCH];
   logic [CW-1:0]   cnt_q   [NCH];
   logic [CW-1:0]   cnt_d   [NCH];

   logic [CW-1:0]   lim;
   logic [NCH-1:0]  exempt;
   logic [NCH-1:0]  to_err;
   logic [NCH-1:0]  err_d;
   logic [NCH-1:0]  err_q;
   logic [NCH-1:0]  sticky_q;

   logic            cap_valid_q;
   logic [3:0]      cap_ch_q;
   logic [AW-1:0]   cap_adr_q;
   logic            cap_we_q;
   logic [7:0]      cap_ovf_q;

   logic            found;
   logic [3:0]      first_ch;
   logic [AW-1:0]   first_adr;
   logic            first_we;
   logic [4:0]      n_err;
   logic [8:0]      ovf_sum;
   logic [7:0]      ovf_acc;
   logic [7:0]      ovf_fresh;

   assign lim = (to_limit_i == '0) ? CW'(pTO) : to_limit_i;

   for (genvar g = 0; g < NCH; g++) begin : g_exempt
      assign exempt[g] = ((adr_i[g*AW +: AW] & pEXMASK) == (pEXBASE & pEXMASK));
   end

   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];
         to_err[n]  = 1'b0;
         case (state_q[n])
            ST_IDLE: begin
               if (cyc_i[n] && stb_i[n] && !ack_i[n]) begin
                  state_d[n] = ST_WAIT;
                  cnt_d[n]   = CW'(1);
               end else begin
                  cnt_d[n]   = '0;
               end
            end
            ST_WAIT: begin
               if (ack_i[n] || !cyc_i[n]) begin
                  state_d[n] = ST_IDLE;
                  cnt_d[n]   = '0;
               end else if (cnt_q[n] < lim) begin
                  if (cnt_q[n] != '1) cnt_d[n] = cnt_q[n] + CW'(1);
               end else if (stb_i[n] && exempt[n]) begin
                  // Exempt targets restart the timer rather than erroring
                  cnt_d[n]   = CW'(1);
               end else begin
                  state_d[n] = ST_ERR;
                  cnt_d[n]   = '0;
                  to_err[n]  = 1'b1;
               end
            end
            ST_ERR: begin
               cnt_d[n] = '0;
               if (!cyc_i[n]) state_d[n] = ST_IDLE;
            end
            default: begin
               state_d[n] = ST_IDLE;
               cnt_d[n]   = '0;
            end
         endcase
         err_d[n] = (state_d[n] == ST_ERR);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= ST_IDLE;
            cnt_q[n]   <= '0;
         end
         err_q    <= '0;
         sticky_q <= '0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
         err_q    <= err_d;
         // Set wins over a simultaneous write-1-to-clear
         sticky_q <= (sticky_q & ~clr_i) | to_err;
      end
   end

   // Pick the lowest-index new error and count all new errors this edge
   always_comb begin
      found     = 1'b0;
      first_ch  = '0;
      first_adr = '0;
      first_we  = 1'b0;
      n_err     = '0;
      for (int n = 0; n < NCH; n++) begin
         if (to_err[n]) begin
            n_err = n_err + 5'd1;
            if (!found) begin
               found     = 1'b1;
               first_ch  = 4'(n);
               first_adr = adr_i[n*AW +: AW];
               first_we  = we_i[n];
            end
         end
      end
   end

   assign ovf_sum   = {1'b0, cap_ovf_q} + {4'b0, n_err};
   assign ovf_acc   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
   assign ovf_fresh = found ? {3'b0, n_err - 5'd1} : 8'h00;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_valid_q <= 1'b0;
         cap_ch_q    <= '0;
         cap_adr_q   <= '0;
         cap_we_q    <= 1'b0;
         cap_ovf_q   <= '0;
      end else if (found) begin
         if (!cap_valid_q || cap_clr_i) begin
            cap_valid_q <= 1'b1;
            cap_ch_q    <= first_ch;
            cap_adr_q   <= first_adr;
            cap_we_q    <= first_we;
            cap_ovf_q   <= ovf_fresh;
         end else begin
            cap_ovf_q   <= ovf_acc;
         end
      end else if (cap_clr_i) begin
         cap_valid_q <= 1'b0;
         cap_ovf_q   <= '0;
      end
   end

   assign err_o        = err_q;
   assign err_sticky_o = sticky_q;
   assign irq_o        = |(sticky_q & irq_en_i);
   assign cap_valid_o  = cap_valid_q;
   assign cap_ch_o     = cap_ch_q;
   assign cap_adr_o    = cap_adr_q;
   assign cap_we_o     = cap_we_q;
   assign cap_ovf_o    = cap_ovf_q;

endmodule

// File: tb/tb_bus_timeout_monitor.sv
// Scoreboard bench for bus_timeout_monitor: directed scenarios plus random traffic,
// expected outputs come from a transaction-level model of the timeout rules.
module tb_bus_timeout_monitor;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int CW  = 16;
   localparam int OW  = NCH + NCH + 1 + 1 + 4 + AW + 1 + 8;

   logic              clk;
   logic              rst;
   logic [NCH-1:0]    cyc, stb, ack, we, clr, irq_en;
   logic [NCH*AW-1:0] adr;
   logic [CW-1:0]     to_limit;
   logic              cap_clr;
   logic [NCH-1:0]    err_o, err_sticky_o;
   logic              irq_o, cap_valid_o, cap_we_o;
   logic [3:0]        cap_ch_o;
   logic [AW-1:0]     cap_adr_o;
   logic [7:0]        cap_ovf_o;

   int n_checks = 0;
   int n_errors = 0;
   string phase = "reset";

   logic [OW-1:0] exp_q[$];
   string         ph_q[$];

   bus_timeout_monitor dut (
      .rst_i(rst), .clk_i(clk), .cyc_i(cyc), .stb_i(stb), .ack_i(ack), .we_i(we),
      .adr_i(adr), .to_limit_i(to_limit), .clr_i(clr), .irq_en_i(irq_en),
      .cap_clr_i(cap_clr), .err_o(err_o), .err_sticky_o(err_sticky_o), .irq_o(irq_o),
      .cap_valid_o(cap_valid_o), .cap_ch_o(cap_ch_o), .cap_adr_o(cap_adr_o),
      .cap_we_o(cap_we_o), .cap_ovf_o(cap_ovf_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   // Reference model: requests age one step per edge, expire past the limit
   bit          m_busy[NCH];
   bit          m_in_err[NCH];
   int          m_age[NCH];
   logic [NCH-1:0] m_sticky;
   bit          m_cv;
   int          m_ch;
   logic [AW-1:0] m_adr;
   bit          m_we;
   int          m_ovf;

   function automatic bit in_window(input logic [AW-1:0] a);
      return a[31:4] == 28'hFFDCFFE;
   endfunction

   task automatic model_step();
      int lim;
      int hits[$];
      logic [AW-1:0] a;
      if (rst) begin
         for (int n = 0; n < NCH; n++) begin
            m_busy[n] = 0; m_in_err[n] = 0; m_age[n] = 0;
         end
         m_sticky = '0; m_cv = 0; m_ch = 0; m_adr = '0; m_we = 0; m_ovf = 0;
         return;
      end
      lim = (to_limit == 0) ? 250 : int'(to_limit);
      for (int n = 0; n < NCH; n++) begin
         a = adr[n*AW +: AW];
         if (m_in_err[n]) begin
            if (!cyc[n]) m_in_err[n] = 0;
         end else if (m_busy[n]) begin
            if (ack[n] || !cyc[n]) begin
               m_busy[n] = 0; m_age[n] = 0;
            end else if (m_age[n] < lim) begin
               if (m_age[n] < 65535) m_age[n] = m_age[n] + 1;
            end else if (stb[n] && in_window(a)) begin
               m_age[n] = 1;
            end else begin
               m_busy[n] = 0; m_in_err[n] = 1; hits.push_back(n);
            end
         end else if (cyc[n] && stb[n] && !ack[n]) begin
            m_busy[n] = 1; m_age[n] = 1;
         end
      end
      m_sticky = m_sticky & ~clr;
      foreach (hits[i]) m_sticky[hits[i]] = 1'b1;
      if (hits.size() > 0) begin
         if (!m_cv || cap_clr) begin
            m_cv = 1; m_ch = hits[0]; m_adr = adr[hits[0]*AW +: AW]; m_we = we[hits[0]];
            m_ovf = hits.size() - 1;
         end else begin
            m_ovf = m_ovf + hits.size();
         end
         if (m_ovf > 255) m_ovf = 255;
      end else if (cap_clr) begin
         m_cv = 0; m_ovf = 0;
      end
   endtask

   function automatic logic [OW-1:0] model_vec();
      logic [NCH-1:0] ev;
      for (int n = 0; n < NCH; n++) ev[n] = m_in_err[n];
      return {ev, m_sticky, |(m_sticky & irq_en), m_cv, 4'(m_ch), m_adr, m_we, 8'(m_ovf)};
   endfunction

   // driver tasks
   task automatic tick();
      model_step();
      exp_q.push_back(model_vec());
      ph_q.push_back(phase);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic set_ch(input int n, input bit c, input bit s, input bit a,
                         input logic [AW-1:0] ad, input bit w);
      cyc[n] = c; stb[n] = s; ack[n] = a; we[n] = w;
      adr[n*AW +: AW] = ad;
   endtask

   task automatic idle_all();
      cyc = '0; stb = '0; ack = '0;
   endtask

   task automatic clean_tick();
      idle_all(); clr = '1; cap_clr = 1'b1;
      tick();
      clr = '0; cap_clr = 1'b0;
   endtask

   // scoreboard monitor
   initial begin
      logic [OW-1:0] e;
      string p;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = ph_q.pop_front();
            check({"sb_", p}, 64'({err_o, err_sticky_o, irq_o, cap_valid_o, cap_ch_o,
                                   cap_adr_o, cap_we_o, cap_ovf_o}), 64'(e));
         end
      end
   end

   initial begin
      rst = 1'b1; cyc = '0; stb = '0; ack = '0; we = '0; adr = '0;
      to_limit = '0; clr = '0; irq_en = '0; cap_clr = 1'b0;
      ticks(3);
      check("reset_err", 64'(err_o), 64'(0));
      check("reset_cap_valid", 64'(cap_valid_o), 64'(0));
      rst = 1'b0;
      tick();

      phase = "rst_mid_wait";
      set_ch(0, 1, 1, 0, 32'h0000_2000, 0);
      ticks(100);
      rst = 1'b1;
      ticks(2);
      check("rst_mid_err", 64'(err_o), 64'(0));
      check("rst_mid_cap_valid", 64'(cap_valid_o), 64'(0));
      rst = 1'b0;
      ticks(250);
      check("default_limit_not_yet", 64'(err_o[0]), 64'(0));
      tick();
      check("default_limit_err", 64'(err_o[0]), 64'(1));

      phase = "runtime_limit";
      to_limit = 16'd4;
      clean_tick();
      set_ch(1, 1, 1, 0, 32'h0000_1000, 1);
      ticks(4);
      check("lim4_not_yet", 64'(err_o[1]), 64'(0));
      tick();
      check("lim4_err", 64'(err_o[1]), 64'(1));
      check("lim4_cap_ch", 64'(cap_ch_o), 64'(1));
      check("lim4_cap_adr", 64'(cap_adr_o), 64'h1000);
      check("lim4_cap_we", 64'(cap_we_o), 64'(1));
      check("lim4_sticky", 64'(err_sticky_o), 64'b0010);
      cyc[1] = 0; stb[1] = 0;
      tick();
      check("lim4_release", 64'(err_o[1]), 64'(0));

      phase = "ack_in_time";
      set_ch(1, 1, 1, 0, 32'h0000_1004, 0);
      ticks(3);
      ack[1] = 1;
      tick();
      check("ack_no_err", 64'(err_o), 64'(0));
      check("ack_status_kept", 64'(err_sticky_o), 64'b0010);
      set_ch(1, 0, 0, 0, 32'h0000_1004, 0);
      tick();
      phase = "back_to_back";
      set_ch(1, 1, 1, 0, 32'h0000_1008, 0);
      ticks(3);
      ack[1] = 1;
      tick();
      ack[1] = 0;
      ticks(4);
      check("b2b_not_yet", 64'(err_o[1]), 64'(0));
      tick();
      check("b2b_err", 64'(err_o[1]), 64'(1));
      idle_all();
      tick();

      phase = "exempt";
      set_ch(1, 1, 1, 0, 32'hFFDC_FFE8, 0);
      ticks(20);
      check("exempt_no_err", 64'(err_o[1]), 64'(0));
      idle_all();
      tick();
      set_ch(1, 1, 1, 0, 32'hFFDC_FFF0, 0);
      ticks(4);
      check("nonexempt_not_yet", 64'(err_o[1]), 64'(0));
      tick();
      check("nonexempt_err", 64'(err_o[1]), 64'(1));
      idle_all();
      tick();

      phase = "simultaneous";
      clean_tick();
      set_ch(2, 1, 1, 0, 32'h0000_3000, 0);
      set_ch(3, 1, 1, 0, 32'h0000_4000, 1);
      ticks(5);
      check("simul_cap_ch", 64'(cap_ch_o), 64'(2));
      check("simul_ovf", 64'(cap_ovf_o), 64'(1));
      idle_all();
      tick();
      set_ch(0, 1, 1, 0, 32'h0000_5000, 0);
      ticks(5);
      check("later_ovf", 64'(cap_ovf_o), 64'(2));
      idle_all();
      tick();
      set_ch(3, 1, 1, 0, 32'h0000_6000, 1);
      ticks(4);
      cap_clr = 1;
      tick();
      cap_clr = 0;
      check("clr_new_cap_ch", 64'(cap_ch_o), 64'(3));
      check("clr_new_ovf", 64'(cap_ovf_o), 64'(0));
      check("clr_new_adr", 64'(cap_adr_o), 64'h6000);
      idle_all();
      tick();

      phase = "sticky_irq";
      irq_en = 4'b0100;
      clean_tick();
      set_ch(2, 1, 1, 0, 32'h0000_7000, 0);
      ticks(5);
      check("irq_set", 64'(irq_o), 64'(1));
      idle_all();
      tick();
      set_ch(2, 1, 1, 0, 32'h0000_7000, 0);
      ticks(4);
      clr[2] = 1;
      tick();
      clr[2] = 0;
      check("sticky_set_wins", 64'(err_sticky_o[2]), 64'(1));
      idle_all();
      tick();
      clr[2] = 1;
      tick();
      clr[2] = 0;
      check("irq_cleared", 64'(irq_o), 64'(0));

      phase = "random";
      for (int t = 0; t < 2500; t++) begin
         if (t % 50 == 0) begin
            to_limit = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            irq_en   = 4'($urandom_range(0, 15));
         end
         for (int n = 0; n < NCH; n++) begin
            if (!cyc[n]) begin
               ack[n] = 0;
               if ($urandom_range(0, 3) == 0) begin
                  cyc[n] = 1; stb[n] = 1; we[n] = 1'($urandom_range(0, 1));
                  case ($urandom_range(0, 3))
                     0:       adr[n*AW +: AW] = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4);
                     1:       adr[n*AW +: AW] = 32'hFFDC_FFE0 | 32'($urandom_range(0, 15));
                     2:       adr[n*AW +: AW] = 32'hFFDC_FFF0 | 32'($urandom_range(0, 15));
                     default: adr[n*AW +: AW] = $urandom;
                  endcase
               end
            end else begin
               cyc[n] = ($urandom_range(0, 11) != 0);
               stb[n] = cyc[n] && ($urandom_range(0, 4) != 0);
               ack[n] = cyc[n] && ($urandom_range(0, 5) == 0);
            end
            clr[n] = ($urandom_range(0, 15) == 0);
         end
         cap_clr = ($urandom_range(0, 19) == 0);
         rst     = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 0; idle_all(); clr = '0; cap_clr = 0;
      tick();
      @(posedge clk);
      #2;
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_timeout_monitor.md
Name: bus_timeout_monitor

Overview:
Multi-channel bus timeout monitor that replaces the single-master timeout error generator. Each of NCH bus masters gets its own timeout counter and state machine. Runtime-programmable limit, a configurable exempt address window that restarts the timer instead of erroring, per-channel sticky status with interrupt, and a first-error capture record with an overflow count. It sits between the masters' cyc/stb/adr outputs and their ack/err inputs, in parallel with the system interconnect.

Parameters:
NCH, 4, number of monitored channels (1..16)
AW, 32, address width per channel
CW, 16, timeout counter width
pTO, 250, default timeout limit in clocks; used when to_limit_i==0
pEXBASE, 32'hFFDCFFE0, exempt window base address (AW bits)
pEXMASK, 32'hFFFFFFF0, exempt match mask; exempt = (adr & pEXMASK) == (pEXBASE & pEXMASK)

Ports:
rst_i  in  1  asynchronous active-high reset
clk_i  in  1  clock
cyc_i  in  NCH  per-channel bus cycle active
stb_i  in  NCH  per-channel strobe
ack_i  in  NCH  per-channel acknowledge from the slave side
we_i  in  NCH  per-channel write enable; captured only
adr_i  in  NCH*AW  per-channel address; channel n is bits [n*AW +: AW]
to_limit_i  in  CW  runtime timeout limit; 0 selects pTO
clr_i  in  NCH  write-1-to-clear for err_sticky_o
irq_en_i  in  NCH  per-channel interrupt enable
cap_clr_i  in  1  clears the capture record
err_o  out  NCH  per-channel bus error to the master; registered
err_sticky_o  out  NCH  per-channel sticky timeout flags
irq_o  out  1  |(err_sticky_o & irq_en_i)
cap_valid_o  out  1  capture record holds an error
cap_ch_o  out  4  channel of the captured error
cap_adr_o  out  AW  address of the captured error
cap_we_o  out  1  we_i of the captured error
cap_ovf_o  out  8  errors lost while cap_valid_o=1; saturates at 255

Behaviour:
- Reset (async, rst_i=1): all channels go to IDLE and all counters clear. Every output and every register go to 0. Reset asserted mid-transaction aborts it; no err_o pulse results.
- lim = (to_limit_i==0) ? pTO : to_limit_i. It is evaluated every cycle, so a change takes effect immediately.
- Per-channel FSM, evaluated at each clk_i rising edge:
  - IDLE: on cyc&stb&!ack, go to WAIT with cnt=1. Otherwise stay, cnt=0.
  - WAIT:
    - ack or !cyc: go to IDLE, cnt=0.
    - else if cnt < lim: cnt++ (saturating at 2^CW-1).
    - else if cnt >= lim and stb and exempt(adr): stay in WAIT, cnt=1, no error.
    - else: go to ERR.
  - ERR: err_o=1. Exit to IDLE only when cyc is sampled low. ack_i in ERR is ignored.
- Timing: first sampled edge e0 with cyc&stb&!ack held gives cnt=lim after edge e0+lim-1 and err_o=1 after edge e0+lim. Example: lim=4, err_o rises after the 5th sampled edge.
- Lowering to_limit_i below the current cnt errors on the next edge. The exempt check still applies.
- Back-to-back cycles: ack and a new stb on the same edge return the channel to IDLE. The next edge restarts the count.
- err_sticky_o[n] sets on the edge of WAIT->ERR and clears on clr_i[n]=1. Set wins over a simultaneous clear.
- Capture, on any WAIT->ERR entry (lowest channel index wins on simultaneous entries):
  - If cap_valid_o=0 or cap_clr_i=1: load ch, adr, we, set cap_valid_o=1, cap_ovf_o=0. All other simultaneous errors add to cap_ovf_o.
  - If cap_valid_o=1 and cap_clr_i=0: cap_ovf_o += number of new errors, saturating at 255.
  - cap_clr_i with no new error: cap_valid_o=0, cap_ovf_o=0; the other capture fields are held.
- irq_o is combinational from registered state and is glitch-free w.r.t. inputs other than irq_en_i.

Test Plan:
- Reset mid-WAIT: ch0 cyc/stb held, no ack, to_limit_i=0; assert rst_i after 100 clocks -> err_o=0, cap_valid_o=0; after release, err_o rises exactly 250 edges after cyc/stb are re-sampled.
- Runtime limit: to_limit_i=4, ch1 cyc/stb held, adr=0x1000, we=1 -> err_o[1]=1 after edge e0+4; cap_ch_o=1, cap_adr_o=0x1000, cap_we_o=1, err_sticky_o=0b0010; drop cyc -> err_o[1]=0 next edge.
- Ack in time: to_limit_i=4, ack on edge e0+3 -> no err_o, cnt=0, status unchanged. Repeat with ack+new stb on the same edge -> second cycle times out independently.
- Exempt window: adr=0xFFDCFFE8, to_limit_i=4, held 20 clocks -> err_o never asserts. Same test with adr=0xFFDCFFF0 -> error at e0+4.
- Simultaneous errors: ch2 and ch3 time out on the same edge -> cap_ch_o=2, cap_ovf_o=1. A later ch0 error -> cap_ovf_o=2. cap_clr_i coinciding with a new ch3 error -> cap_ch_o=3, cap_ovf_o=0.
- Sticky/irq: irq_en_i=0b0100, ch2 error -> irq_o=1. clr_i[2]=1 on the same edge as a new ch2 error -> sticky stays 1. Then clr_i[2] alone -> irq_o=0.
